// File: rtl/apb_pkg.sv
// Shared APB master definitions: FSM state encoding and default bus widths.
package apb_pkg;

  localparam int unsigned APB_DATA_WIDTH     = 32;
  localparam int unsigned APB_ADDR_WIDTH     = 32;
  localparam int unsigned APB_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

endpackage

// File: rtl/apb_master_fsm.sv
// APB master: turns upstream valid/ready commands into APB SETUP/ACCESS
// transfers, with a wait-state timeout that aborts a stalled slave.
module apb_master_fsm
  import apb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  // upstream command / response
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  // APB
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  apb_state_e            state_q, state_d;
  logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;

  logic                  cmd_ready_d;
  logic                  rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_d;
  logic                  rsp_err_d;
  logic [ADDR_WIDTH-1:0] paddr_d;
  logic                  psel_d;
  logic                  penable_d;
  logic                  pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_d;

  // Next-state and next-output logic; every output is the registered copy of its _d.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    paddr_d     = PADDR;
    psel_d      = PSEL;
    penable_d   = PENABLE;
    pwrite_d    = PWRITE;
    pwdata_d    = PWDATA;

    case (state_q)
      IDLE: begin
        // cmd_ready is only ever high while in IDLE
        if (cmd_valid && cmd_ready) begin
          paddr_d   = cmd_addr;
          pwrite_d  = cmd_write;
          pwdata_d  = cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d  = 1'b1;
        wait_cnt_d = '0;
        state_d    = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          // completion wins over the timeout on the limit edge
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = PSLVERR;
          rsp_rdata_d = PWRITE ? '0 : PRDATA;
          state_d     = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
          if (wait_cnt_q == CNT_LAST) begin
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            state_d     = IDLE;
          end
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      PADDR      <= '0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PWDATA     <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      cmd_ready  <= cmd_ready_d;
      rsp_valid  <= rsp_valid_d;
      rsp_rdata  <= rsp_rdata_d;
      rsp_err    <= rsp_err_d;
      PADDR      <= paddr_d;
      PSEL       <= psel_d;
      PENABLE    <= penable_d;
      PWRITE     <= pwrite_d;
      PWDATA     <= pwdata_d;
    end
  end

endmodule

// File: tb/tb_apb_master_fsm.sv
// Directed bench for apb_master_fsm with a behavioural APB slave that decodes
// 0x00-0x0C and can insert wait states or stall forever.
module tb_apb_master_fsm;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = 32'h0;
  logic [31:0] cmd_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA = 32'hBAD0BAD0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b1;

  int n_vec  = 0;
  int n_miss = 0;

  // slave behaviour knobs
  int   slave_waits = 0;
  logic slave_hang  = 1'b0;
  int   wait_left   = 0;
  logic [31:0] mem [4] = '{32'h00000A00, 32'h0, 32'h0, 32'h0};

  apb_master_fsm #(
    .DATA_WIDTH    (32),
    .ADDR_WIDTH    (32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .PADDR    (PADDR),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // Slave: responds on the falling edge so the master samples settled values.
  // Outside a ready ACCESS cycle it drives junk on PRDATA/PSLVERR.
  always @(negedge PCLK) begin
    if (PSEL && !PENABLE) begin
      wait_left <= slave_waits;
      PREADY    <= 1'b0;
      PSLVERR   <= 1'b1;
      PRDATA    <= 32'hBAD0BAD0;
    end else if (PSEL && PENABLE) begin
      if (slave_hang || wait_left != 0) begin
        PREADY  <= 1'b0;
        PSLVERR <= 1'b1;
        PRDATA  <= 32'h5A5A5A5A;
        if (wait_left != 0) wait_left <= wait_left - 1;
      end else begin
        PREADY <= 1'b1;
        if (PADDR < 32'h10) begin
          PSLVERR <= 1'b0;
          if (PWRITE) begin
            mem[PADDR[3:2]] <= PWDATA;
            PRDATA          <= 32'h77777777;
          end else begin
            PRDATA <= mem[PADDR[3:2]];
          end
        end else begin
          PSLVERR <= 1'b1;
          PRDATA  <= 32'hE0E0E0E0;
        end
      end
    end else begin
      PREADY  <= 1'b0;
      PSLVERR <= 1'b1;
      PRDATA  <= 32'hBAD0BAD0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one command and observe it from the acceptance edge (k=0) onwards.
  task automatic run_cmd(
    input  logic        wr,
    input  logic [31:0] a,
    input  logic [31:0] d,
    output int          psel_lat,
    output int          pen_lat,
    output int          rsp_lat,
    output int          n_acc,
    output int          pulses,
    output logic        err,
    output logic [31:0] rdata,
    output logic        stable,
    output logic        ready_after,
    output logic [31:0] rdata_after,
    output logic [31:0] paddr_after
  );
    int guard;
    psel_lat = -1; pen_lat = -1; rsp_lat = -1; n_acc = 0; pulses = 0;
    err = 1'bx; rdata = 32'hx; stable = 1'b1;
    ready_after = 1'b0; rdata_after = 32'hx; paddr_after = 32'hx;
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(posedge PCLK); #1;
      guard++;
    end
    if (!cmd_ready) begin
      chk("cmd_ready_wait", 32'(cmd_ready), 32'h1);
      return;
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    @(posedge PCLK); #1;
    cmd_valid = 1'b0; cmd_addr = 32'hFFFFFFF0; cmd_wdata = 32'hCAFEF00D; cmd_write = ~wr;
    for (int k = 0; k < 40; k++) begin
      if (PSEL && psel_lat < 0) psel_lat = k;
      if (PENABLE && pen_lat < 0) pen_lat = k;
      if (PSEL && PENABLE) n_acc++;
      if (PSEL && (PADDR !== a || PWRITE !== wr || PWDATA !== d)) stable = 1'b0;
      if (rsp_valid) begin
        pulses++;
        if (rsp_lat < 0) begin
          rsp_lat = k;
          err     = rsp_err;
          rdata   = rsp_rdata;
          if (PSEL || PENABLE) stable = 1'b0;
        end
      end
      if (rsp_lat >= 0 && k == rsp_lat + 1) begin
        ready_after = cmd_ready;
        rdata_after = rsp_rdata;
        paddr_after = PADDR;
      end
      if (rsp_lat >= 0 && k >= rsp_lat + 3) break;
      @(posedge PCLK); #1;
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_acc;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int psel_lat, pen_lat, rsp_lat, n_acc, pulses;
    logic err, stable, ready_after;
    logic [31:0] rdata, rdata_after, paddr_after;
    int rst_pulses;

    vecs[0] = '{1'b1, 32'h04, 32'h22222222, 0,  1'b0, 32'h00000000, 1};
    vecs[1] = '{1'b0, 32'h04, 32'h00000000, 0,  1'b0, 32'h22222222, 1};
    vecs[2] = '{1'b1, 32'h10, 32'hDEADBEEF, 0,  1'b1, 32'h00000000, 1};
    vecs[3] = '{1'b0, 32'h20, 32'h11111111, 0,  1'b1, 32'hE0E0E0E0, 1};
    vecs[4] = '{1'b1, 32'h08, 32'h12345678, 3,  1'b0, 32'h00000000, 4};
    vecs[5] = '{1'b0, 32'h08, 32'h0000FFFF, 1,  1'b0, 32'h12345678, 2};
    vecs[6] = '{1'b0, 32'h00, 32'h00000000, 0,  1'b0, 32'h00000A00, 1};
    vecs[7] = '{1'b0, 32'h04, 32'h00000000, 15, 1'b0, 32'h22222222, 16};

    // reset state
    PRESET = 1'b1;
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_psel",      32'(PSEL),      32'h0);
    chk("rst_penable",   32'(PENABLE),   32'h0);
    chk("rst_pwrite",    32'(PWRITE),    32'h0);
    chk("rst_paddr",     PADDR,          32'h0);
    chk("rst_pwdata",    PWDATA,         32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata,      32'h0);
    chk("rst_rsp_err",   32'(rsp_err),   32'h0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h0);
    PRESET = 1'b0;
    @(posedge PCLK); #1;
    chk("cmd_ready_after_reset", 32'(cmd_ready), 32'h1);

    // table-driven transfers
    for (int i = 0; i < 8; i++) begin
      slave_waits = vecs[i].waits;
      slave_hang  = 1'b0;
      run_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, psel_lat, pen_lat, rsp_lat,
              n_acc, pulses, err, rdata, stable, ready_after, rdata_after, paddr_after);
      chk($sformatf("v%0d_psel_lat", i),    32'(psel_lat), 32'(0));
      chk($sformatf("v%0d_penable_lat", i), 32'(pen_lat),  32'(1));
      chk($sformatf("v%0d_rsp_lat", i),     32'(rsp_lat),  32'(vecs[i].exp_acc + 1));
      chk($sformatf("v%0d_access_cycles", i), 32'(n_acc),  32'(vecs[i].exp_acc));
      chk($sformatf("v%0d_rsp_pulses", i),  32'(pulses),   32'(1));
      chk($sformatf("v%0d_rsp_err", i),     32'(err),      32'(vecs[i].exp_err));
      chk($sformatf("v%0d_rsp_rdata", i),   rdata,         vecs[i].exp_rdata);
      chk($sformatf("v%0d_apb_stable", i),  32'(stable),   32'h1);
      chk($sformatf("v%0d_ready_after", i), 32'(ready_after), 32'h1);
      chk($sformatf("v%0d_rdata_hold", i),  rdata_after,   vecs[i].exp_rdata);
      chk($sformatf("v%0d_paddr_hold", i),  paddr_after,   vecs[i].addr);
    end

    // timeout: slave never ready
    slave_waits = 0;
    slave_hang  = 1'b1;
    run_cmd(1'b0, 32'h08, 32'h0, psel_lat, pen_lat, rsp_lat, n_acc, pulses,
            err, rdata, stable, ready_after, rdata_after, paddr_after);
    chk("to_access_cycles", 32'(n_acc),       32'(16));
    chk("to_rsp_lat",       32'(rsp_lat),     32'(17));
    chk("to_rsp_pulses",    32'(pulses),      32'(1));
    chk("to_rsp_err",       32'(err),         32'h1);
    chk("to_rsp_rdata",     rdata,            32'h0);
    chk("to_apb_stable",    32'(stable),      32'h1);
    chk("to_ready_after",   32'(ready_after), 32'h1);
    slave_hang = 1'b0;

    // reset in the second ACCESS cycle of a stalled write
    slave_waits = 5;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0C; cmd_wdata = 32'h0C0C0C0C;
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    chk("rr_setup_psel", 32'(PSEL), 32'h1);
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    chk("rr_in_access", 32'(PSEL && PENABLE), 32'h1);
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    chk("rr_psel",      32'(PSEL),      32'h0);
    chk("rr_penable",   32'(PENABLE),   32'h0);
    chk("rr_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rr_cmd_ready", 32'(cmd_ready), 32'h0);
    chk("rr_rsp_rdata", rsp_rdata,      32'h0);
    PRESET = 1'b0;
    rst_pulses = 0;
    @(posedge PCLK); #1;
    chk("rr_cmd_ready_after", 32'(cmd_ready), 32'h1);
    for (int k = 0; k < 4; k++) begin
      if (rsp_valid) rst_pulses++;
      @(posedge PCLK); #1;
    end
    chk("rr_no_rsp", 32'(rst_pulses), 32'h0);

    // next command after reset completes normally; aborted write left 0x0C untouched
    slave_waits = 0;
    run_cmd(1'b0, 32'h0C, 32'h0, psel_lat, pen_lat, rsp_lat, n_acc, pulses,
            err, rdata, stable, ready_after, rdata_after, paddr_after);
    chk("post_rst_rsp_lat", 32'(rsp_lat), 32'(2));
    chk("post_rst_rsp_err", 32'(err),     32'h0);
    chk("post_rst_rdata",   rdata,        32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Global time bound so a stuck handshake cannot hang the run.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

endmodule
